// File: rtl/camera_downsampler.sv
// OV7670 capture front end: packs RGB565 byte pairs into RGB332 pixels and
// generates frame-buffer write strobes/addresses for one stored frame.
module camera_downsampler #(
    parameter int SCREEN_WIDTH  = 176,
    parameter int SCREEN_HEIGHT = 144
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [7:0]  CAM_DATA,
    input  logic        CAM_HREF,
    input  logic        CAM_VSYNC,
    output logic [7:0]  PIXEL_OUT,
    output logic        W_EN,
    output logic [14:0] WRITE_ADDR,
    output logic        FRAME_DONE,
    output logic        FRAME_ERR
);

    localparam int COL_W = $clog2(SCREEN_WIDTH + 1);
    localparam int ROW_W = $clog2(SCREEN_HEIGHT + 1);
    localparam logic [COL_W-1:0] COL_LIMIT   = COL_W'(SCREEN_WIDTH);
    localparam logic [COL_W-1:0] COL_ONE     = COL_W'(1);
    localparam logic [ROW_W-1:0] ROW_LIMIT   = ROW_W'(SCREEN_HEIGHT);
    localparam logic [ROW_W-1:0] ROW_ONE     = ROW_W'(1);
    localparam logic [14:0]      LINE_STRIDE = 15'(SCREEN_WIDTH);

    typedef enum logic [1:0] {
        WAIT_VSYNC,
        WAIT_FRAME,
        ACTIVE
    } state_t;

    state_t state, state_next;

    logic             href_prev;
    logic             vsync_prev;
    logic             phase;
    logic [5:0]       first_rg;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             extra_line;
    logic [14:0]      addr;
    logic [14:0]      row_base;

    logic start_frame;
    logic frame_end;
    logic line_end;
    logic capture;
    logic in_bounds;
    logic frame_bad;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= WAIT_VSYNC;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        start_frame = 1'b0;
        frame_end   = 1'b0;
        case (state)
            WAIT_VSYNC: begin
                if (CAM_VSYNC) begin
                    state_next = WAIT_FRAME;
                end
            end
            WAIT_FRAME: begin
                if (!CAM_VSYNC) begin
                    state_next  = ACTIVE;
                    start_frame = 1'b1;
                end
            end
            ACTIVE: begin
                if (CAM_VSYNC && !vsync_prev) begin
                    state_next = WAIT_FRAME;
                    frame_end  = 1'b1;
                end
            end
            default: begin
                state_next = WAIT_VSYNC;
            end
        endcase
    end

    // extra_line catches frames longer than the stored height, since row saturates
    always_comb begin
        line_end  = (state == ACTIVE) && href_prev && !CAM_HREF;
        capture   = (state == ACTIVE) && CAM_HREF;
        in_bounds = (col < COL_LIMIT) && (row < ROW_LIMIT);
        frame_bad = (row != ROW_LIMIT) || extra_line;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            href_prev  <= 1'b0;
            vsync_prev <= 1'b0;
            phase      <= 1'b0;
            first_rg   <= '0;
            col        <= '0;
            row        <= '0;
            extra_line <= 1'b0;
            addr       <= '0;
            row_base   <= '0;
            PIXEL_OUT  <= '0;
            W_EN       <= 1'b0;
            WRITE_ADDR <= '0;
            FRAME_DONE <= 1'b0;
            FRAME_ERR  <= 1'b0;
        end else begin
            W_EN       <= 1'b0;
            FRAME_DONE <= 1'b0;
            FRAME_ERR  <= 1'b0;
            href_prev  <= CAM_HREF;
            vsync_prev <= CAM_VSYNC;

            if (start_frame) begin
                col        <= '0;
                row        <= '0;
                extra_line <= 1'b0;
                addr       <= '0;
                row_base   <= '0;
                phase      <= 1'b0;
            end else if (line_end) begin
                // A dangling first byte is dropped by forcing phase back to 0
                col   <= '0;
                phase <= 1'b0;
                if (row != ROW_LIMIT) begin
                    row      <= row + ROW_ONE;
                    row_base <= row_base + LINE_STRIDE;
                    addr     <= row_base + LINE_STRIDE;
                end else begin
                    extra_line <= 1'b1;
                end
            end else if (capture) begin
                phase <= ~phase;
                if (!phase) begin
                    first_rg <= {CAM_DATA[7:5], CAM_DATA[2:0]};
                end else if (in_bounds) begin
                    PIXEL_OUT  <= {first_rg, CAM_DATA[4:3]};
                    WRITE_ADDR <= addr;
                    W_EN       <= 1'b1;
                    addr       <= addr + 15'd1;
                    col        <= col + COL_ONE;
                end
            end

            if (frame_end) begin
                FRAME_DONE <= 1'b1;
                FRAME_ERR  <= frame_bad;
            end
        end
    end

endmodule

// File: tb/tb_camera_downsampler.sv
// Self-checking bench for camera_downsampler: a frame-level model predicts every
// write and frame pulse cycle-by-cycle; literal checks pin the model.
module tb_camera_downsampler;

    localparam int W = 176;
    localparam int H = 144;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [7:0]  CAM_DATA = 8'h00;
    logic        CAM_HREF = 1'b0;
    logic        CAM_VSYNC = 1'b0;
    logic [7:0]  PIXEL_OUT;
    logic        W_EN;
    logic [14:0] WRITE_ADDR;
    logic        FRAME_DONE;
    logic        FRAME_ERR;

    camera_downsampler #(
        .SCREEN_WIDTH (W),
        .SCREEN_HEIGHT(H)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .CAM_DATA  (CAM_DATA),
        .CAM_HREF  (CAM_HREF),
        .CAM_VSYNC (CAM_VSYNC),
        .PIXEL_OUT (PIXEL_OUT),
        .W_EN      (W_EN),
        .WRITE_ADDR(WRITE_ADDR),
        .FRAME_DONE(FRAME_DONE),
        .FRAME_ERR (FRAME_ERR)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [14:0] addr;
        logic [7:0]  pix;
    } wr_t;

    typedef struct {
        int   cyc;
        logic err;
    } fr_t;

    wr_t exp_wr[$];
    fr_t exp_fr[$];

    int  n_checks = 0;
    int  n_pass = 0;
    bit  check_en = 1'b0;

    bit  m_active = 1'b0;
    int  m_lines = 0;

    int          wr_count = 0;
    int          fd_count = 0;
    int          fe_count = 0;
    logic [14:0] addr_log[$];
    logic [7:0]  pix_log[$];
    logic [7:0]  line_q[$];

    function automatic logic [7:0] rgb565_to_332(input logic [7:0] hi, input logic [7:0] lo);
        logic [15:0] p;
        p = {hi, lo};
        return {p[15:13], p[10:8], p[4:3]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Cycle-exact comparison of every output against the model queues
    always @(negedge CLK) begin
        logic exp_w;
        logic exp_f;
        logic exp_e;
        if (check_en) begin
            exp_w = (exp_wr.size() > 0) && (exp_wr[0].cyc == cyc);
            checkOutput("w_en", W_EN, exp_w);
            if (exp_w) begin
                checkOutput("write_addr", WRITE_ADDR, exp_wr[0].addr);
                checkOutput("pixel_out", PIXEL_OUT, exp_wr[0].pix);
                void'(exp_wr.pop_front());
            end
            exp_f = (exp_fr.size() > 0) && (exp_fr[0].cyc == cyc);
            exp_e = exp_f ? exp_fr[0].err : 1'b0;
            checkOutput("frame_done", FRAME_DONE, exp_f);
            checkOutput("frame_err", FRAME_ERR, exp_e);
            if (exp_f) void'(exp_fr.pop_front());
            if (W_EN === 1'b1) begin
                wr_count++;
                addr_log.push_back(WRITE_ADDR);
                pix_log.push_back(PIXEL_OUT);
            end
            if (FRAME_DONE === 1'b1) fd_count++;
            if (FRAME_ERR === 1'b1) fe_count++;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            CAM_HREF = 1'b0;
            CAM_DATA = 8'($urandom);
        end
    endtask

    task automatic fill_random(input int n);
        line_q.delete();
        for (int i = 0; i < n; i++) line_q.push_back(8'($urandom));
    endtask

    task automatic reset_stats();
        wr_count = 0;
        fd_count = 0;
        fe_count = 0;
        addr_log.delete();
        pix_log.delete();
    endtask

    // Drive one HREF line from line_q; the model predicts each pair's write
    task automatic applyStimulus();
        wr_t w;
        for (int i = 0; i < line_q.size(); i++) begin
            tick();
            CAM_HREF = 1'b1;
            CAM_DATA = line_q[i];
            if (m_active && (i % 2 == 1) && (i / 2 < W) && (m_lines < H)) begin
                w.cyc  = cyc + 1;
                w.addr = 15'(m_lines * W + i / 2);
                w.pix  = rgb565_to_332(line_q[i-1], line_q[i]);
                exp_wr.push_back(w);
            end
        end
        idle(4);
        if (m_active) m_lines++;
    endtask

    task automatic frame_start();
        tick();
        CAM_VSYNC = 1'b1;
        CAM_HREF  = 1'b0;
        idle(3);
        tick();
        CAM_VSYNC = 1'b0;
        m_active  = 1'b1;
        m_lines   = 0;
        idle(2);
    endtask

    task automatic frame_end();
        fr_t f;
        tick();
        CAM_VSYNC = 1'b1;
        if (m_active) begin
            f.cyc = cyc + 1;
            f.err = (m_lines != H);
            exp_fr.push_back(f);
        end
        m_active = 1'b0;
        idle(3);
    endtask

    task automatic do_reset();
        tick();
        RESET    = 1'b1;
        CAM_HREF = 1'b0;
        m_active = 1'b0;
        m_lines  = 0;
        exp_wr.delete();
        tick();
        checkOutput("reset_w_en", W_EN, 1'b0);
        checkOutput("reset_pixel", PIXEL_OUT, 8'h00);
        checkOutput("reset_addr", WRITE_ADDR, 15'd0);
        checkOutput("reset_done", FRAME_DONE, 1'b0);
        checkOutput("reset_err", FRAME_ERR, 1'b0);
        idle(2);
        tick();
        RESET = 1'b0;
    endtask

    initial begin
        int bad_order;
        RESET = 1'b1;
        repeat (3) tick();
        check_en = 1'b1;
        checkOutput("init_w_en", W_EN, 1'b0);
        checkOutput("init_pixel", PIXEL_OUT, 8'h00);
        checkOutput("init_addr", WRITE_ADDR, 15'd0);
        checkOutput("init_done", FRAME_DONE, 1'b0);
        checkOutput("init_err", FRAME_ERR, 1'b0);
        tick();
        RESET = 1'b0;

        $display("[TB] pre-sync HREF activity");
        reset_stats();
        fill_random(40);
        applyStimulus();
        tick();
        CAM_VSYNC = 1'b1;
        applyStimulus();
        checkOutput("presync_writes", wr_count, 0);

        $display("[TB] byte packing");
        reset_stats();
        frame_start();
        line_q.delete();
        line_q.push_back(8'hF8);
        line_q.push_back(8'h1F);
        line_q.push_back(8'h07);
        line_q.push_back(8'hE0);
        applyStimulus();
        frame_end();
        checkOutput("pack_count", wr_count, 2);
        checkOutput("pack_addr0", addr_log[0], 15'd0);
        checkOutput("pack_pix0", pix_log[0], 8'hE3);
        checkOutput("pack_addr1", addr_log[1], 15'd1);
        checkOutput("pack_pix1", pix_log[1], 8'h1C);
        checkOutput("pack_done", fd_count, 1);
        checkOutput("pack_err", fe_count, 1);

        $display("[TB] oversize line, odd lines, short frame");
        reset_stats();
        frame_start();
        fill_random(400);
        applyStimulus();
        fill_random(4);
        applyStimulus();
        for (int l = 0; l < 98; l++) begin
            fill_random(3);
            applyStimulus();
        end
        frame_end();
        checkOutput("short_count", wr_count, 276);
        checkOutput("oversize_last", addr_log[175], 15'd175);
        checkOutput("next_line_start", addr_log[176], 15'd176);
        checkOutput("odd_line_start", addr_log[178], 15'd352);
        checkOutput("short_done", fd_count, 1);
        checkOutput("short_err", fe_count, 1);

        $display("[TB] long frame");
        reset_stats();
        frame_start();
        for (int l = 0; l < H + 2; l++) begin
            fill_random(2);
            applyStimulus();
        end
        frame_end();
        checkOutput("long_count", wr_count, H);
        checkOutput("long_last_addr", addr_log[H-1], 15'd25168);
        checkOutput("long_err", fe_count, 1);

        $display("[TB] reset mid-frame");
        reset_stats();
        frame_start();
        for (int l = 0; l < 50; l++) begin
            fill_random(16);
            applyStimulus();
        end
        do_reset();
        idle(5);
        checkOutput("abandon_done", fd_count, 0);
        checkOutput("abandon_count", wr_count, 400);

        $display("[TB] full frame");
        reset_stats();
        frame_start();
        for (int l = 0; l < H; l++) begin
            fill_random(2 * W);
            applyStimulus();
        end
        frame_end();
        bad_order = 0;
        foreach (addr_log[i]) if (addr_log[i] != 15'(i)) bad_order++;
        checkOutput("full_count", wr_count, W * H);
        checkOutput("full_first", addr_log[0], 15'd0);
        checkOutput("full_last", addr_log[W*H-1], 15'd25343);
        checkOutput("full_order", bad_order, 0);
        checkOutput("full_done", fd_count, 1);
        checkOutput("full_err", fe_count, 0);

        idle(5);
        checkOutput("pending_writes", exp_wr.size(), 0);
        checkOutput("pending_frames", exp_fr.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/camera_downsampler.md
# camera_downsampler

Capture front end for the OV7670 path. Samples the camera's 8-bit parallel bus in the camera pixel-clock domain and packs each RGB565 byte pair into one RGB332 pixel. Produces frame-buffer write strobes and linear addresses for a `SCREEN_WIDTH` x `SCREEN_HEIGHT` frame. The frame buffer it fills is the pixel source for the downstream image processor and VGA path, so every pixel that stage consumes originates here.

## Interface
Parameters:
- `SCREEN_WIDTH`, 176, pixels per stored line.
- `SCREEN_HEIGHT`, 144, lines per stored frame.

Ports:
- `CLK`  in  1  camera pixel clock (PCLK); sole clock.
- `RESET`  in  1  synchronous, active-high reset.
- `CAM_DATA`  in  8  camera data byte, valid while `CAM_HREF` is high.
- `CAM_HREF`  in  1  line-valid strobe.
- `CAM_VSYNC`  in  1  frame sync; high between frames.
- `PIXEL_OUT`  out  8  RGB332 pixel: [7:5] R, [4:2] G, [1:0] B.
- `W_EN`  out  1  one-cycle frame-buffer write enable for `PIXEL_OUT`/`WRITE_ADDR`.
- `WRITE_ADDR`  out  15  linear address, row*`SCREEN_WIDTH`+col.
- `FRAME_DONE`  out  1  one-cycle pulse at end of each captured frame.
- `FRAME_ERR`  out  1  one-cycle pulse coincident with `FRAME_DONE` when the frame was not exactly `SCREEN_HEIGHT` lines.

## Operation
- FSM states:
  - WAIT_VSYNC (reset state): waits for `CAM_VSYNC`=1, then goes to WAIT_FRAME.
  - WAIT_FRAME: on `CAM_VSYNC`=0, clears col, row, address and byte phase, then goes to ACTIVE.
  - ACTIVE: captures bytes; on `CAM_VSYNC` rising edge, goes to WAIT_FRAME.
- Capture, in ACTIVE with `CAM_HREF`=1:
  - Byte phase toggles every cycle.
  - Phase 0 latches the first byte, holding R[4:0] in [7:3] and G[5:3] in [2:0].
  - Phase 1 forms RGB332 as R = first[7:5], G = {first[2:0]} upper 3 G bits (G[5:3]), B = second[4:3].
  - Phase 1 asserts `W_EN` for one cycle, then increments col.
- Column bounds: when col ≥ `SCREEN_WIDTH` or row ≥ `SCREEN_HEIGHT`, the pixel is dropped. `W_EN` stays 0 and col saturates (no wrap).
- Address generation is an incrementing register; no multiplier.
  - The address advances by 1 on each written pixel.
  - At each line end it is set to (row+1)*`SCREEN_WIDTH`, maintained as a running row base plus `SCREEN_WIDTH`.
- Line end is the `CAM_HREF` falling edge, detected from the previous-cycle `CAM_HREF` register. It increments row (saturating at `SCREEN_HEIGHT`), clears col, and resets phase to 0.
  - A dangling phase-0 byte at line end is discarded.
- Frame end is the `CAM_VSYNC` rising edge while in ACTIVE.
  - `FRAME_DONE` pulses for 1 cycle.
  - `FRAME_ERR` pulses in the same cycle if the completed-line count ≠ `SCREEN_HEIGHT` (short or long frame).
  - Counters clear when the FSM next enters ACTIVE.
- `CAM_HREF` high in WAIT_VSYNC or WAIT_FRAME is ignored.
- `RESET` mid-frame: the FSM returns to WAIT_VSYNC and all counters clear. The partial frame is abandoned; no `FRAME_DONE` is produced for it.

## Timing
- All inputs are sampled on rising `CLK`; all outputs are registered.
- Reset values: `PIXEL_OUT`=0, `W_EN`=0, `WRITE_ADDR`=0, `FRAME_DONE`=0, `FRAME_ERR`=0, FSM=WAIT_VSYNC, col=row=phase=0.
- Latency: `W_EN`, `PIXEL_OUT` and `WRITE_ADDR` become valid the cycle after the phase-1 byte is sampled. All three are held stable for that cycle only.
- Throughput: one write every 2 cycles while `CAM_HREF`=1.
- `W_EN` is never high in consecutive cycles.
- `FRAME_DONE` is asserted the cycle after the `CAM_VSYNC` rising edge is sampled.
- A line-end write and an HREF fall in the same cycle are not possible: a phase-1 byte completes before the fall is seen. Any write from the last byte pair of a line still issues.
- `WRITE_ADDR` range is 0..`SCREEN_WIDTH`*`SCREEN_HEIGHT`-1 (0..25343); an out-of-range address is never emitted with `W_EN`=1.

## Test plan
- **Byte packing:** after reset, VSYNC high→low, one line of bytes 0xF8,0x1F then 0x07,0xE0 → two writes: addr 0 with `PIXEL_OUT`=0xE3, addr 1 with 0x1C.
- **Full frame:** 144 lines × 352 bytes, then VSYNC rise → 25344 writes at addresses 0..25343 in order; `FRAME_DONE`=1 for one cycle; `FRAME_ERR`=0.
- **Oversize line:** a line of 400 bytes → exactly 176 writes; the next line starts at address 176.
- **Odd byte / short frame:** line with 3 bytes → 1 write and the odd byte is dropped; a 100-line frame → `FRAME_DONE` and `FRAME_ERR` both pulse.
- **Reset mid-frame:** assert `RESET` at line 50 → outputs return to reset values next cycle; no `FRAME_DONE`; the next full frame writes from address 0.
- **Pre-sync HREF:** HREF activity before the first VSYNC → no `W_EN` pulses.
